// File: rtl/erec_pkg.sv
// Shared widths, recovery-level encoding and ep mask helper for the
// error-recovery stage of the approximate multiplier.
package erec_pkg;

   localparam int unsigned G_LSB  = 1;
   localparam int unsigned G_MSB  = 31;
   localparam int unsigned EP_LSB = 9;
   localparam int unsigned EP_MSB = 24;
   localparam int unsigned P_W    = 32;

   localparam int unsigned G_W  = G_MSB - G_LSB + 1;
   localparam int unsigned EP_W = EP_MSB - EP_LSB + 1;
   localparam int unsigned H_W  = P_W / 2;

   typedef enum logic [1:0] {
      REC_NONE  = 2'd0,
      REC_TOP8  = 2'd1,
      REC_TOP12 = 2'd2,
      REC_FULL  = 2'd3
   } rec_level_e;

   // Bit k of the mask selects ep[k+EP_LSB]; deeper levels reach further down.
   function automatic logic [EP_W-1:0] ep_mask(input rec_level_e lvl);
      logic [EP_W-1:0] m;
      case (lvl)
         REC_TOP8:  m = 16'hFF00;
         REC_TOP12: m = 16'hFFF0;
         REC_FULL:  m = 16'hFFFF;
         default:   m = 16'h0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/erec_pipe_reg.sv
// Valid/ready register slice: captures payload when loaded with a valid beat,
// holds it under stall.
module erec_pipe_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= data_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/error_recovery_stage.sv
// Final multiplier stage: adds a level-selected slice of the error vector back
// onto the approximate sum through a two-stage carry-split pipeline.
module error_recovery_stage
   import erec_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [G_W-1:0]   in_g,
   input  logic [EP_W-1:0]  in_ep,
   input  logic             in_p0,
   input  logic [1:0]       rec_level,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [P_W-1:0]   out_p,
   output logic             out_ovf,
   output logic [CNT_W-1:0] rec_count
);

   // Stage 1 payload: {lo sum, c16, A hi, B hi}; stage 2 payload: {ovf, product}.
   localparam int unsigned S1_W = 3 * H_W + 1;
   localparam int unsigned S2_W = P_W + 1;

   logic [EP_W-1:0]  masked_ep;
   logic [P_W-1:0]   a_op;
   logic [P_W-1:0]   b_op;
   logic [H_W:0]     lo_sum;
   logic [H_W:0]     hi_sum;
   logic [H_W-1:0]   lo_q;
   logic             c16_q;
   logic [H_W-1:0]   a_hi_q;
   logic [H_W-1:0]   b_hi_q;
   logic [S1_W-1:0]  s1_d;
   logic [S1_W-1:0]  s1_q;
   logic [S2_W-1:0]  s2_d;
   logic [S2_W-1:0]  s2_q;
   logic             v1;
   logic             v2;
   logic             ld1;
   logic             ld2;
   logic             accept;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   assign ld2      = !v2 || out_ready;
   assign ld1      = !v1 || ld2;
   assign in_ready = ld1;
   assign accept   = in_valid && in_ready;

   always_comb begin
      masked_ep = in_ep & ep_mask(rec_level_e'(rec_level));
      a_op      = {in_g, in_p0};
      b_op      = '0;
      // ep[i] carries weight 2^(i+1).
      b_op[EP_MSB+1:EP_LSB+1] = masked_ep;
      lo_sum    = {1'b0, a_op[H_W-1:0]} + {1'b0, b_op[H_W-1:0]};
      s1_d      = {lo_sum[H_W-1:0], lo_sum[H_W], a_op[P_W-1:H_W], b_op[P_W-1:H_W]};
   end

   erec_pipe_reg #(
      .W (S1_W)
   ) u_stage1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (ld1),
      .valid_i (accept),
      .data_i  (s1_d),
      .valid_o (v1),
      .data_o  (s1_q)
   );

   always_comb begin
      lo_q   = s1_q[S1_W-1 -: H_W];
      c16_q  = s1_q[2*H_W];
      a_hi_q = s1_q[2*H_W-1 -: H_W];
      b_hi_q = s1_q[H_W-1:0];
      hi_sum = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{H_W{1'b0}}, c16_q};
      s2_d   = {hi_sum[H_W], hi_sum[H_W-1:0], lo_q};
   end

   erec_pipe_reg #(
      .W (S2_W)
   ) u_stage2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (ld2),
      .valid_i (v1),
      .data_i  (s2_d),
      .valid_o (v2),
      .data_o  (s2_q)
   );

   assign out_valid = v2;
   assign out_p     = s2_q[P_W-1:0];
   assign out_ovf   = s2_q[P_W];

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (|masked_ep) && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rec_count = cnt_q;

endmodule

// File: tb/tb_error_recovery_stage.sv
// Self-checking bench: table-driven single beats, directed backpressure and
// reset sequences, random streaming checked by an in-order scoreboard.
module tb_error_recovery_stage;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [30:0]      in_g = '0;
   logic [15:0]      in_ep = '0;
   logic             in_p0 = 1'b0;
   logic [1:0]       rec_level = 2'd0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_p;
   logic             out_ovf;
   logic [CNT_W-1:0] rec_count;

   always #5 clk = ~clk;

   error_recovery_stage #(
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_g      (in_g),
      .in_ep     (in_ep),
      .in_p0     (in_p0),
      .rec_level (rec_level),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_ovf   (out_ovf),
      .rec_count (rec_count)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          n_popped = 0;
   logic [32:0] sb_q[$];
   logic [32:0] sb_exp;

   typedef struct {
      logic [30:0] g;
      logic [15:0] ep;
      logic        p0;
      logic [1:0]  lvl;
      logic [31:0] p;
      logic        ovf;
      logic [3:0]  cnt;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic [30:0] g, input logic [15:0] ep,
                                         input logic p0, input logic [1:0] lvl);
      logic [15:0] keep;
      case (lvl)
         2'd0:    keep = 16'h0000;
         2'd1:    keep = {8'hFF, 8'h00};
         2'd2:    keep = {12'hFFF, 4'h0};
         default: keep = 16'hFFFF;
      endcase
      return {1'b0, g, p0} + ({17'b0, ep & keep} << 10);
   endfunction

   // Decide at the falling edge what the next rising edge will accept/deliver.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: got %0h, want no output", out_p);
            end else begin
               sb_exp = sb_q.pop_front();
               chk("sb_result", {31'b0, out_ovf, out_p}, {31'b0, sb_exp});
               n_popped++;
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(in_g, in_ep, in_p0, rec_level));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [30:0] g, input logic [15:0] ep, input logic p0,
                           input logic [1:0] lvl);
      in_g      = g;
      in_ep     = ep;
      in_p0     = p0;
      rec_level = lvl;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int cyc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while ((sb_q.size() != 0 || out_valid) && cyc < 20) begin
         tick();
         cyc++;
      end
      chk(name, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      logic [32:0] b0;
      int          acc;
      int          cyc;
      int          pop0;
      logic        take;

      #200000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [32:0] b0;
      int          acc;
      int          cyc;
      int          pop0;
      logic        take;

      vt[0] = '{31'h0000_0800, 16'h0001, 1'b0, 2'd3, 32'h0000_1400, 1'b0, 4'd1};
      vt[1] = '{31'h0000_0800, 16'h0001, 1'b0, 2'd2, 32'h0000_1000, 1'b0, 4'd1};
      vt[2] = '{31'h0000_7FFF, 16'h0020, 1'b0, 2'd3, 32'h0001_7FFE, 1'b0, 4'd2};
      vt[3] = '{31'h7FFF_FFFF, 16'h8000, 1'b0, 2'd1, 32'h01FF_FFFE, 1'b1, 4'd3};
      vt[4] = '{31'h1234_5678, 16'hFFFF, 1'b1, 2'd0, 32'h2468_ACF1, 1'b0, 4'd3};
      vt[5] = '{31'h0000_0000, 16'h00FF, 1'b1, 2'd1, 32'h0000_0001, 1'b0, 4'd3};
      vt[6] = '{31'h0000_0000, 16'hFFFF, 1'b0, 2'd2, 32'h03FF_C000, 1'b0, 4'd4};
      vt[7] = '{31'h7FFF_FFFF, 16'hFFFF, 1'b1, 2'd3, 32'h03FF_FBFF, 1'b1, 4'd5};

      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_count", rec_count, 0);
      chk("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         set_beat(vt[i].g, vt[i].ep, vt[i].p0, vt[i].lvl);
         in_valid = 1'b1;
         chk($sformatf("tv%0d_in_ready", i), in_ready, 1);
         tick();
         in_valid = 1'b0;
         chk($sformatf("tv%0d_not_early", i), out_valid, 0);
         tick();
         chk($sformatf("tv%0d_out_valid", i), out_valid, 1);
         chk($sformatf("tv%0d_out_p", i), out_p, vt[i].p);
         chk($sformatf("tv%0d_out_ovf", i), out_ovf, vt[i].ovf);
         chk($sformatf("tv%0d_count", i), rec_count, vt[i].cnt);
         tick();
      end
      drain("tv_drain");

      // Backpressure: out_ready low for three cycles while four beats stream in.
      pop0 = n_popped;
      b0   = model(31'd3, 16'h0001, 1'b0, 2'd3);
      out_ready = 1'b0;
      set_beat(31'd3, 16'h0001, 1'b0, 2'd3);
      in_valid = 1'b1;
      chk("bp_ready0", in_ready, 1);
      tick();
      set_beat(31'd103, 16'h0002, 1'b0, 2'd3);
      chk("bp_ready1", in_ready, 1);
      tick();
      set_beat(31'd203, 16'h0004, 1'b0, 2'd3);
      chk("bp_ready2", in_ready, 0);
      chk("bp_valid2", out_valid, 1);
      chk("bp_p2", out_p, b0[31:0]);
      chk("bp_cnt2", rec_count, 7);
      tick();
      chk("bp_ready3", in_ready, 0);
      chk("bp_valid3", out_valid, 1);
      chk("bp_hold3", out_p, b0[31:0]);
      chk("bp_cnt_hold", rec_count, 7);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_full_shift", in_ready, 1);
      tick();
      set_beat(31'd303, 16'h0008, 1'b0, 2'd3);
      chk("bp_ready4", in_ready, 1);
      tick();
      drain("bp_drain");
      chk("bp_delivered", 64'(n_popped - pop0), 64'd4);
      chk("bp_cnt_end", rec_count, 9);

      // Random stream with random backpressure.
      acc  = 0;
      cyc  = 0;
      take = 1'b1;
      while (acc < 40 && cyc < 2000) begin
         if (!in_valid || take) begin
            set_beat(31'($urandom), 16'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         take = in_valid && in_ready;
         if (take) acc++;
         tick();
         cyc++;
      end
      if (acc < 40) begin
         chk("rand_budget", 64'(acc), 64'd40);
      end
      drain("rand_drain");

      // Saturation then mid-stream reset.
      do_reset();
      chk("sat_start", rec_count, 0);
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         set_beat(31'(k), 16'h8000 | 16'(k), 1'b0, 2'd3);
         tick();
      end
      chk("sat_count", rec_count, 15);
      chk("sat_valid", out_valid, 1);
      set_beat(31'd77, 16'hFFFF, 1'b1, 2'd3);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", rec_count, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_p", out_p, 0);
      tick();
      chk("mid_rst_valid2", out_valid, 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_count", rec_count, 0);
      drain("final_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/error_recovery_stage.md
Name: error_recovery_stage

Overview:
- Final stage of the approximate multiplier with error recovery. Sits directly downstream of the last approximate-compression layer.
- Consumes that layer's approximate partial sum vector g[31:1] and error vector ep[24:9], plus the product LSB. Adds back a selectable portion of the error vector to produce the recovered 32-bit product.
- Two-stage carry-split pipeline with valid/ready handshake and a saturating recovery-event counter.

Parameters:
- CNT_W, 16, width of the recovery-event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_g  input  31  approximate sum bits g[31:1]; bit index i has weight 2^i.
- in_ep  input  16  error bits ep[24:9]; ep[i] has weight 2^(i+1).
- in_p0  input  1  product bit 0.
- rec_level  input  2  recovery depth, sampled with each accepted beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_p  output  32  recovered product, modulo 2^32.
- out_ovf  output  1  recovery add carried out of bit 31.
- rec_count  output  CNT_W  saturating count of accepted beats whose masked ep is nonzero.

Behaviour:
- Reset: all valid flags 0, out_p 0, out_ovf 0, rec_count 0. in_ready is 1 in the cycle after reset deasserts.
- A beat is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- Masking of ep by rec_level:
  - 0: none recovered (mask 0).
  - 1: ep[24:17].
  - 2: ep[24:13].
  - 3: ep[24:9].
  - Masked bits are forced to 0.
- Operands:
  - A = {in_g, in_p0} (32 bits).
  - B = masked_ep zero-extended and shifted so ep[i] lands at bit i+1, occupying bits 25:10.
- Stage 1, on accept:
  - Compute A[15:0]+B[15:0].
  - Register the 16-bit low sum, carry c16, A[31:16], B[31:16].
  - Set v1.
- Stage 2, when advancing:
  - Compute A[31:16]+B[31:16]+c16.
  - out_p = {hi[15:0], lo}; out_ovf = carry out of the high add.
  - Set v2 (drives out_valid).
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput is 1 beat per cycle.
- Stall rules:
  - Stage 2 loads when !v2 || out_ready.
  - Stage 1 loads when !v1 || stage 2 loads.
  - in_ready = !v1 || !v2 || out_ready (combinational).
  - Under stall, out_p and out_ovf hold stable while out_valid = 1.
- Bubbles: when stage 1 advances with no new accept, v1 clears. When stage 2 unloads with v1 = 0, v2 clears.
- rec_count:
  - Increments at accept when masked_ep != 0.
  - Saturates at all-ones; no wrap.
  - Holds when in_valid && !in_ready.
- Simultaneous accept and deliver with both stages full: the pipeline shifts in one cycle, with no bubble and no loss.
- rst mid-operation: in-flight beats are discarded and all state returns to reset values on that edge. out_valid never glitches high during reset.
- rec_level is not registered separately; only its effect through the mask is carried.

Decomposition:
- Shared package (erec_pkg) holds:
  - Width constants: G_LSB=1, G_MSB=31, EP_LSB=9, EP_MSB=24, P_W=32.
  - Typedef for rec_level with names REC_NONE, REC_TOP8, REC_TOP12, REC_FULL.
  - Function returning the 16-bit ep mask per level.
- One natural sub-module, erec_pipe_reg: a valid/ready register slice instantiated twice with payload width parameterised.

Test Plan:
- g[12]=1, others 0; ep[9]=1; p0=0; level 3 -> out_p=0x0000_1400, ovf=0, rec_count=1 after 2 cycles.
- Same beat, level 2 -> out_p=0x0000_1000, rec_count unchanged.
- Carry across halves: A=0x0000_FFFE, ep[14]=1 (B=0x8000), level 3 -> low half overflows, out_p=0x0001_7FFE, ovf=0.
- Overflow: A=0xFFFF_FFFE, ep[24]=1, level 1 -> out_p=0x01FF_FFFE, out_ovf=1.
- Backpressure: stream 4 beats with out_ready low 3 cycles:
  - in_ready drops after 2 accepts.
  - out_p holds stable.
  - All 4 results emerge in order, none dropped or duplicated.
- rec_count saturation: CNT_W=4, 20 beats with nonzero masked ep -> rec_count=15. Then assert rst mid-stream -> next cycle out_valid=0, rec_count=0, in_ready=1.
